muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide engine in the execute stage. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. While working it raises a stall request that the hazard unit consumes as its `stall_execute` source, and it aborts when the hazard unit flushes execute. It is the requester side of the stall/flush handshake.

---
 rtl/muldiv_unit_pkg.sv | 32 +++
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit.sv | 120 ++++++++++++
 tb/tb_muldiv_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide engine.
// The op encodings are the funct3 field of the M instruction.
package muldiv_unit_pkg;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'b000,
        MULDIV_MULH   = 3'b001,
        MULDIV_MULHSU = 3'b010,
        MULDIV_MULHU  = 3'b011,
        MULDIV_DIV    = 3'b100,
        MULDIV_DIVU   = 3'b101,
        MULDIV_REM    = 3'b110,
        MULDIV_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic rs1_is_signed(input md_op_e op);
        return op inside {MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
    endfunction

    function automatic logic rs2_is_signed(input md_op_e op);
        return op inside {MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage <-> muldiv handshake; execute is master, the engine is slave.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1_data, rs2_data, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, rs1_data, rs2_data, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M engine: 32-cycle shift-add multiply / restoring divide on
// operand magnitudes, with a single shared 64-bit adder and one output negator.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  md
);

    md_state_e         r_state, w_state_nxt;
    md_op_e            r_op;
    logic [4:0]        r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic              r_neg;

    md_op_e            w_op;
    logic              w_accept, w_s1, w_s2, w_div_zero, w_ovf, w_fast, w_neg;
    logic [2*XLEN-1:0] w_add_a, w_add_b, w_sum;
    logic              w_add_sub;
    logic              w_lo_sel, w_cin;
    logic [XLEN-1:0]   w_sel, w_res;

    assign w_op       = md_op_e'(md.op);
    assign w_accept   = (r_state == MD_IDLE) && md.start && !md.flush;
    assign w_s1       = rs1_is_signed(w_op) && md.rs1_data[XLEN-1];
    assign w_s2       = rs2_is_signed(w_op) && md.rs2_data[XLEN-1];
    assign w_div_zero = w_op[2] && (md.rs2_data == '0);
    assign w_ovf      = (w_op == MULDIV_DIV || w_op == MULDIV_REM)
                        && (md.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                        && (md.rs2_data == '1);
    assign w_fast     = w_div_zero || w_ovf;
    // Remainder follows the dividend; every other signed result follows the sign product.
    assign w_neg      = (w_op == MULDIV_REM) ? w_s1 : (w_s1 ^ w_s2);

    // In IDLE the adder forms both operand magnitudes at once: the low half
    // never carries into the high half because ~rs2 of a negative rs2 is < 2^31.
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_sub = 1'b0;
        if (r_state == MD_IDLE) begin
            w_add_a = {w_s1 ? ~md.rs1_data : md.rs1_data,
                       w_s2 ? ~md.rs2_data : md.rs2_data};
            w_add_b = {{(XLEN-1){1'b0}}, w_s1, {(XLEN-1){1'b0}}, w_s2};
        end else if (r_op[2]) begin
            w_add_a   = {{(XLEN-1){1'b0}}, r_acc[2*XLEN-1:XLEN-1]};
            w_add_b   = {{XLEN{1'b0}}, r_opb};
            w_add_sub = 1'b1;
        end else begin
            w_add_a = {{XLEN{1'b0}}, r_acc[2*XLEN-1:XLEN]};
            w_add_b = {{XLEN{1'b0}}, r_acc[0] ? r_opb : {XLEN{1'b0}}};
        end
    end

    assign w_sum = w_add_a + (w_add_sub ? ~w_add_b : w_add_b) + {{(2*XLEN-1){1'b0}}, w_add_sub};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            MD_IDLE: if (w_accept) w_state_nxt = w_fast ? MD_DONE : MD_RUN;
            MD_RUN:  if (r_cnt == 5'(MULDIV_ITERS - 1)) w_state_nxt = MD_DONE;
            MD_DONE: w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
        if (md.flush) w_state_nxt = MD_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= MD_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op  <= MULDIV_MUL;
            r_cnt <= '0;
            r_acc <= '0;
            r_opb <= '0;
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_op  <= w_op;
            r_cnt <= '0;
            r_neg <= w_fast ? 1'b0 : w_neg;
            if (w_div_zero) begin
                r_acc <= {md.rs1_data, {XLEN{1'b1}}};
                r_opb <= '0;
            end else if (w_ovf) begin
                r_acc <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                r_opb <= '0;
            end else begin
                r_acc <= {{XLEN{1'b0}}, w_sum[2*XLEN-1:XLEN]};
                r_opb <= w_sum[XLEN-1:0];
            end
        end else if (r_state == MD_RUN && !md.flush) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_op[2]) begin
                // Restoring step: keep the difference only when it did not go negative.
                if (!w_sum[2*XLEN-1]) r_acc <= {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
                else                  r_acc <= {r_acc[2*XLEN-2:0], 1'b0};
            end else begin
                r_acc <= {w_sum[XLEN:0], r_acc[XLEN-1:1]};
            end
        end
    end

    // High word of a negated 64-bit product needs the borrow from the low word.
    assign w_lo_sel = (r_op == MULDIV_MUL) || (r_op == MULDIV_DIV) || (r_op == MULDIV_DIVU);
    assign w_sel    = w_lo_sel ? r_acc[XLEN-1:0] : r_acc[2*XLEN-1:XLEN];
    assign w_cin    = r_op[2] || w_lo_sel || (r_acc[XLEN-1:0] == '0);
    assign w_res    = r_neg ? (~w_sel + {{(XLEN-1){1'b0}}, w_cin}) : w_sel;

    assign md.busy   = reset && (w_accept || (r_state == MD_RUN));
    assign md.done   = (r_state == MD_DONE);
    assign md.result = (r_state == MD_DONE) ? w_res : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic model.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) md();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .md(md));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, ub;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'd0, b});
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] corner [6];
        corner = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    // Called mid-cycle with the engine idle; accepts in this cycle.
    // flush_at / rst_at kill the op in that cycle after accept (0 = never).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int rst_at);
        int          lat;
        logic [31:0] exp;
        lat = is_fast(op, a, b) ? 1 : 33;
        exp = ref_md(op, a, b);
        md.start = 1'b1; md.op = op; md.rs1_data = a; md.rs2_data = b; md.flush = 1'b0;
        #1;
        chk("busy_accept", 32'(md.busy), 32'd1);
        chk("done_accept", 32'(md.done), 32'd0);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk); #1;
            md.rs1_data = $urandom;
            md.rs2_data = $urandom;
            if (i == lat) begin
                chk("done_pulse", 32'(md.done), 32'd1);
                chk("busy_done", 32'(md.busy), 32'd0);
                chk($sformatf("result op%0d a=%08h b=%08h", op, a, b), md.result, exp);
                md.start = 1'b0;
            end else begin
                chk("busy_run", 32'(md.busy), 32'd1);
                chk("done_run", 32'(md.done), 32'd0);
                chk("result_run", md.result, 32'd0);
                if (i == flush_at) begin
                    md.flush = 1'b1;
                    @(posedge clk); #1;
                    md.flush = 1'b0;
                    md.start = 1'b0;
                    #1;
                    chk("busy_after_flush", 32'(md.busy), 32'd0);
                    chk("done_after_flush", 32'(md.done), 32'd0);
                    return;
                end
                if (i == rst_at) begin
                    reset = 1'b0;
                    #1;
                    chk("busy_in_reset", 32'(md.busy), 32'd0);
                    chk("done_in_reset", 32'(md.done), 32'd0);
                    chk("result_in_reset", md.result, 32'd0);
                    md.start = 1'b0;
                    #1 reset = 1'b1;
                    #1;
                    return;
                end
            end
        end
        @(posedge clk); #1;
        chk("done_clear", 32'(md.done), 32'd0);
        chk("busy_idle", 32'(md.busy), 32'd0);
        chk("result_idle", md.result, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        md.start = 1'b0; md.op = 3'd0; md.rs1_data = '0; md.rs2_data = '0; md.flush = 1'b0;
        #12;
        chk("reset_busy", 32'(md.busy), 32'd0);
        chk("reset_done", 32'(md.done), 32'd0);
        chk("reset_result", md.result, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_op(3'd5, 32'd100, 32'd7, 0, 0);
        do_op(3'd7, 32'd100, 32'd7, 0, 0);
        do_op(3'd5, 32'd5, 32'd0, 0, 0);
        do_op(3'd6, 32'd5, 32'd0, 0, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

        do_op(3'd4, 32'd1000, 32'd7, 10, 0);
        do_op(3'd5, 32'd9, 32'd3, 0, 0);

        do_op(3'd0, 32'd123, 32'd456, 0, 5);
        do_op(3'd0, 32'd6, 32'd7, 0, 0);

        repeat (60) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            do_op(op, a, b, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
